// File: rtl/relay_arbiter_pkg.sv
// Shared types and defaults for the relay arbiter: state encoding, default
// parameter values and width helpers.
package relay_arbiter_pkg;

  localparam int unsigned NReqDefault   = 4;
  localparam int unsigned HoldDefault   = 8;
  localparam int unsigned SettleDefault = 2;

  // Relay sequencing states; StFault is only reachable with contact feedback enabled.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArm     = 3'd1,
    StDrive   = 3'd2,
    StRelease = 3'd3,
    StFault   = 3'd4
  } state_e;

  // Counter must hold HOLD-1 and SETTLE-1 without wrapping.
  function automatic int unsigned cnt_width(int unsigned hold, int unsigned settle);
    return $clog2(hold + settle) + 1;
  endfunction

  // Index width for a requester pointer; never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relay_arbiter_if.sv
// Request/grant and relay control bundle between requesting logic, the arbiter
// and the relay. master = requester/relay side, slave = arbiter side.
interface relay_arbiter_if #(
  parameter int unsigned N_REQ = 4
);

  logic [N_REQ-1:0] req;
  logic             c;
  logic [N_REQ-1:0] grant;
  logic             switch;
  logic             batt;
  logic             busy;
  logic             done;
  logic             fault;

  modport master (
    output req,
    output c,
    input  grant,
    input  switch,
    input  batt,
    input  busy,
    input  done,
    input  fault
  );

  modport slave (
    input  req,
    input  c,
    output grant,
    output switch,
    output batt,
    output busy,
    output done,
    output fault
  );

endinterface

// File: rtl/relay_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request at or after
// ptr_i (wrapping modulo N_REQ) and returns it one-hot and as an index.
module relay_arbiter_rr_pick import relay_arbiter_pkg::*; #(
  parameter int unsigned N_REQ = NReqDefault,
  localparam int unsigned IdxW = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic             valid_o,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IdxW-1:0]  idx_o
);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  // Scan from ptr_i upward; the first hit wins.
  always_comb begin
    valid_o  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand     = (32'(ptr_i) + i) % N_REQ;
      cand_idx = IdxW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o            = 1'b1;
        onehot_o[cand_idx] = 1'b1;
        idx_o              = cand_idx;
      end
    end
  end

endmodule

// File: rtl/relay_arbiter.sv
// Round-robin arbiter sharing one battery/relay pair among N_REQ requesters.
// Each grant runs break-before-make: arm battery, drive coil for HOLD cycles,
// release, settle for SETTLE cycles. All outputs are registered.
// Optional contact feedback checking is enabled by defining RELAY_ARB_FEEDBACK_EN.
module relay_arbiter import relay_arbiter_pkg::*; #(
  parameter int unsigned N_REQ  = NReqDefault,
  parameter int unsigned HOLD   = HoldDefault,
  parameter int unsigned SETTLE = SettleDefault
) (
  input logic           clk,
  input logic           rst_n,
  relay_arbiter_if.slave bus
);

  localparam int unsigned CntW = cnt_width(HOLD, SETTLE);
  localparam int unsigned IdxW = idx_width(N_REQ);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             switch_q, switch_d;
  logic             batt_q, batt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;

  logic             pick_valid;
  logic [N_REQ-1:0] pick_onehot;
  logic [IdxW-1:0]  pick_idx;
  logic             owner_req;

  relay_arbiter_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  assign owner_req = |(bus.req & grant_q);

`ifdef RELAY_ARB_FEEDBACK_EN
  logic fault_q, fault_d;
  // Set only in IDLE reached through RELEASE, so a reset-interrupted drive is not
  // mistaken for a welded contact.
  logic weld_chk_q, weld_chk_d;
  logic fb_fail;

  // The first DRIVE cycle is exempt: the contact needs one cycle to follow the coil.
  assign fb_fail = (cnt_q != CntW'(HOLD - 1)) && !bus.c;
`else
  logic unused_c;
  assign unused_c = bus.c;
`endif

  // Next-state and registered-output computation for the relay sequence.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    switch_d = switch_q;
    batt_d   = batt_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    done_d   = 1'b0;
`ifdef RELAY_ARB_FEEDBACK_EN
    fault_d  = fault_q;
`endif

    case (state_q)
      StIdle: begin
`ifdef RELAY_ARB_FEEDBACK_EN
        if (weld_chk_q && bus.c) begin
          state_d  = StFault;
          fault_d  = 1'b1;
          grant_d  = '0;
          switch_d = 1'b0;
          batt_d   = 1'b0;
        end else
`endif
        if (pick_valid) begin
          state_d  = StArm;
          grant_d  = pick_onehot;
          batt_d   = 1'b1;
          switch_d = 1'b0;
          ptr_d    = (pick_idx == IdxW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
      end

      StArm: begin
        state_d  = StDrive;
        switch_d = 1'b1;
        batt_d   = 1'b1;
        cnt_d    = CntW'(HOLD - 1);
      end

      StDrive: begin
`ifdef RELAY_ARB_FEEDBACK_EN
        if (fb_fail) begin
          state_d  = StFault;
          fault_d  = 1'b1;
          grant_d  = '0;
          switch_d = 1'b0;
          batt_d   = 1'b0;
        end else
`endif
        if (!owner_req || (cnt_q == '0)) begin
          // An owner that drops its request ends early without a completion pulse.
          state_d  = StRelease;
          grant_d  = '0;
          switch_d = 1'b0;
          batt_d   = 1'b0;
          cnt_d    = CntW'(SETTLE - 1);
          done_d   = owner_req;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StRelease: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

`ifdef RELAY_ARB_FEEDBACK_EN
      StFault: begin
        grant_d  = '0;
        switch_d = 1'b0;
        batt_d   = 1'b0;
      end
`endif

      default: begin
        state_d  = StIdle;
        grant_d  = '0;
        switch_d = 1'b0;
        batt_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);

`ifdef RELAY_ARB_FEEDBACK_EN
    weld_chk_d = (state_d == StIdle) && ((state_q == StRelease) || weld_chk_q);
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      switch_q   <= 1'b0;
      batt_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= '0;
`ifdef RELAY_ARB_FEEDBACK_EN
      fault_q    <= 1'b0;
      weld_chk_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      switch_q   <= switch_d;
      batt_q     <= batt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
`ifdef RELAY_ARB_FEEDBACK_EN
      fault_q    <= fault_d;
      weld_chk_q <= weld_chk_d;
`endif
    end
  end

  assign bus.grant  = grant_q;
  assign bus.switch = switch_q;
  assign bus.batt   = batt_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
`ifdef RELAY_ARB_FEEDBACK_EN
  assign bus.fault  = fault_q;
`else
  assign bus.fault  = 1'b0;
`endif

  // At most one owner, and the coil is never driven without the battery armed.
  assert property (@(posedge clk) $onehot0(grant_q));
  assert property (@(posedge clk) switch_q |-> batt_q);

endmodule

// File: tb/tb_relay_arbiter.sv
// Self-checking bench for relay_arbiter (N_REQ=4, HOLD=8, SETTLE=2). A simple relay
// model closes its contact one cycle after switch&batt; c_kill forces the contact open.
module tb_relay_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic c_relay = 1'b0;
  logic c_kill = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  relay_arbiter_if #(.N_REQ(4)) bus ();

  relay_arbiter #(
    .N_REQ  (4),
    .HOLD   (8),
    .SETTLE (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) c_relay <= bus.switch & bus.batt;
  assign bus.c = c_relay & ~c_kill;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    c_kill  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    c_kill  = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
    checks++; if (bus.switch !== 1'b0) begin failures++; $display("FAIL reset_switch got=%b exp=0", bus.switch); end
    checks++; if (bus.batt !== 1'b0) begin failures++; $display("FAIL reset_batt got=%b exp=0", bus.batt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if ({bus.done, bus.fault} !== 2'b00) begin failures++; $display("FAIL reset_done_fault got=%b exp=00", {bus.done, bus.fault}); end
    bus.req = '0;
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int   nsw, ndone, w;
    logic got;
    logic [3:0] last;
    exp_t e;
    do_reset();
    bus.req = 4'b0100;
    @(negedge clk);
    checks++; if (bus.grant !== 4'b0100) begin failures++; $display("FAIL single_grant_t1 got=%b exp=0100", bus.grant); end
    checks++; if ({bus.batt, bus.switch, bus.busy} !== 3'b101) begin failures++; $display("FAIL single_arm_t1 got=%b exp=101", {bus.batt, bus.switch, bus.busy}); end
    nsw = 0;
    ndone = 0;
    for (int t = 2; t <= 9; t++) begin
      @(negedge clk);
      if (bus.switch === 1'b1) nsw++;
      if (bus.done === 1'b1) ndone++;
    end
    checks++; if (nsw !== 8) begin failures++; $display("FAIL single_switch_cycles got=%0d exp=8", nsw); end
    @(negedge clk);
    checks++; if ({bus.switch, bus.batt, bus.grant} !== 6'b0) begin failures++; $display("FAIL single_release_t10 got=%b exp=000000", {bus.switch, bus.batt, bus.grant}); end
    if (bus.done === 1'b1) ndone++;
    sb.push_back('{grant: 4'b0100, gap: 3});
    last = bus.grant;
    got  = 1'b0;
    w    = 0;
    while (!got && w < 40) begin
      @(negedge clk);
      w++;
      if (bus.done === 1'b1) ndone++;
      if (bus.grant !== 4'b0000 && last === 4'b0000) got = 1'b1;
      last = bus.grant;
    end
    e = sb.pop_front();
    checks++; if (ndone !== 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", ndone); end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL single_regrant_seen got=%b exp=1", got); end
    checks++; if (bus.grant !== e.grant) begin failures++; $display("FAIL single_regrant got=%b exp=%b", bus.grant, e.grant); end
    checks++; if (w !== e.gap) begin failures++; $display("FAIL single_regrant_gap got=%0d exp=%0d", w, e.gap); end
    bus.req = '0;
  endtask

  task automatic test_fairness();
    int   w, k;
    logic got;
    logic [3:0] last;
    exp_t e;
    do_reset();
    sb.push_back('{grant: 4'b0001, gap: 1});
    sb.push_back('{grant: 4'b0010, gap: 12});
    sb.push_back('{grant: 4'b0100, gap: 12});
    sb.push_back('{grant: 4'b1000, gap: 12});
    sb.push_back('{grant: 4'b0001, gap: 12});
    bus.req = 4'b1111;
    last = bus.grant;
    k = 0;
    while (sb.size() != 0) begin
      e   = sb.pop_front();
      got = 1'b0;
      w   = 0;
      while (!got && w < 40) begin
        @(negedge clk);
        w++;
        if (bus.grant !== 4'b0000 && last === 4'b0000) got = 1'b1;
        last = bus.grant;
      end
      checks++; if (got !== 1'b1 || bus.grant !== e.grant) begin failures++; $display("FAIL fair_grant%0d got=%b exp=%b", k, bus.grant, e.grant); end
      checks++; if (w !== e.gap) begin failures++; $display("FAIL fair_gap%0d got=%0d exp=%0d", k, w, e.gap); end
      k++;
    end
    bus.req = '0;
  endtask

  task automatic test_early_drop();
    int ndone;
    do_reset();
    bus.req = 4'b0001;
    repeat (4) @(negedge clk);
    checks++; if (bus.switch !== 1'b1) begin failures++; $display("FAIL drop_switch_t4 got=%b exp=1", bus.switch); end
    bus.req = 4'b0000;
    @(negedge clk);
    checks++; if ({bus.switch, bus.batt, bus.grant} !== 6'b0) begin failures++; $display("FAIL drop_release_t5 got=%b exp=000000", {bus.switch, bus.batt, bus.grant}); end
    ndone = (bus.done === 1'b1) ? 1 : 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL drop_idle_t7 busy got=%b exp=0", bus.busy); end
    repeat (4) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL drop_no_done got=%0d exp=0", ndone); end
  endtask

  task automatic test_reset_mid();
    int   w;
    logic got;
    logic [3:0] last;
    exp_t e;
    do_reset();
    bus.req = 4'b0100;
    repeat (5) @(negedge clk);
    checks++; if (bus.switch !== 1'b1) begin failures++; $display("FAIL midrst_drive_t5 got=%b exp=1", bus.switch); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({bus.grant, bus.switch, bus.batt, bus.busy, bus.done} !== 8'b0) begin failures++; $display("FAIL midrst_outputs got=%b exp=00000000", {bus.grant, bus.switch, bus.batt, bus.busy, bus.done}); end
    sb.push_back('{grant: 4'b0001, gap: 1});
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    last = bus.grant;
    got  = 1'b0;
    w    = 0;
    while (!got && w < 40) begin
      @(negedge clk);
      w++;
      if (bus.grant !== 4'b0000 && last === 4'b0000) got = 1'b1;
      last = bus.grant;
    end
    e = sb.pop_front();
    checks++; if (got !== 1'b1 || bus.grant !== e.grant) begin failures++; $display("FAIL midrst_ptr_restart got=%b exp=%b", bus.grant, e.grant); end
    checks++; if (w !== e.gap) begin failures++; $display("FAIL midrst_latency got=%0d exp=%0d", w, e.gap); end
    bus.req = '0;
  endtask

  task automatic test_feedback();
    int ndone;
    do_reset();
    bus.req = 4'b0001;
    repeat (3) @(negedge clk);
    c_kill = 1'b1;
    @(negedge clk);
    c_kill = 1'b0;
`ifdef RELAY_ARB_FEEDBACK_EN
    checks++; if (bus.fault !== 1'b1) begin failures++; $display("FAIL fb_fault_set got=%b exp=1", bus.fault); end
    checks++; if ({bus.switch, bus.batt, bus.grant} !== 6'b0) begin failures++; $display("FAIL fb_outputs_off got=%b exp=000000", {bus.switch, bus.batt, bus.grant}); end
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    checks++; if ({bus.fault, bus.grant} !== 5'b10000) begin failures++; $display("FAIL fb_sticky got=%b exp=10000", {bus.fault, bus.grant}); end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL fb_no_done got=%0d exp=0", ndone); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL fb_fault_cleared got=%b exp=0", bus.fault); end
    rst_n = 1'b1;
`else
    checks++; if ({bus.fault, bus.switch} !== 2'b01) begin failures++; $display("FAIL nofb_drive_t4 got=%b exp=01", {bus.fault, bus.switch}); end
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL nofb_done_count got=%0d exp=1", ndone); end
    checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL nofb_fault got=%b exp=0", bus.fault); end
`endif
    bus.req = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.req = '0;
    test_reset();
    test_single();
    test_fairness();
    test_early_drop();
    test_reset_mid();
    test_feedback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
